// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the SRAM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int MAX_REQ = 4;

  // Requester index; two bits cover MAX_REQ requesters.
  typedef logic [1:0] id_t;

  // One entry of the read-tag pipeline: which requester owns the read in flight.
  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter: request bus plus read-response return.
// Latency: n/a (wiring only).
// Backpressure: req_ready grants one requester per cycle; rsp_* has no backpressure.
// Ports: req_valid/req_we/req_addr/req_wdata (flattened per requester) from requesters,
//        req_ready (one-hot-or-zero), rsp_valid (one-hot-or-zero), rsp_data back to requesters.
interface sram_port_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;

  // Requester side drives requests and consumes grants/responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sram_port_arbiter_rr_pick.sv
// Round-robin winner selection: first valid requester scanning upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; grant is one-hot when any valid is set, otherwise zero.
// Ports: valid (per-requester request), ptr (scan start) -> grant (one-hot), winner_id.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]  valid,
  input  sram_arb_pkg::id_t ptr,
  output logic [N_REQ-1:0]  grant,
  output sram_arb_pkg::id_t winner_id
);

  import sram_arb_pkg::*;

  logic       w_found;
  logic [2:0] w_idx;

  always_comb begin
    w_found   = 1'b0;
    winner_id = '0;
    w_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Candidate index ptr+k, wrapped into 0..N_REQ-1 (ptr+k < 2*N_REQ).
      w_idx = {1'b0, ptr} + 3'(k);
      if (w_idx >= 3'(N_REQ)) begin
        w_idx = w_idx - 3'(N_REQ);
      end
      // Constant-index lookup keeps the select free of variable bit indexing.
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_found && valid[i] && (w_idx == 3'(i))) begin
          w_found   = 1'b1;
          winner_id = id_t'(i);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = w_found && (winner_id == id_t'(i));
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N_REQ requesters, routing read data back.
// Latency: accept in cycle N -> SRAM pins N+1 -> rsp_valid/rsp_data N+3; one access per cycle.
// Backpressure: req_ready is the grant (gated by arb_en and reset); responses cannot be stalled.
// Ports: clk, reset (sync, active-high), arb_en, req_if (requester bundle), arb_busy,
//        sram_read_data in; sram_we, sram_read_addr, sram_write_addr, sram_write_data out (registered).
module sram_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arb_en,
  sram_port_arbiter_if.slave req_if,
  output logic               arb_busy,
  input  logic [DATA_W-1:0]  sram_read_data,
  output logic               sram_we,
  output logic [ADDR_W-1:0]  sram_read_addr,
  output logic [ADDR_W-1:0]  sram_write_addr,
  output logic [DATA_W-1:0]  sram_write_data
);

  import sram_arb_pkg::*;

  logic [N_REQ-1:0]  w_grant;
  id_t               w_winner;
  id_t               w_ptr_nxt;
  logic              w_accept;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [N_REQ-1:0]  w_rsp_onehot;

  id_t               r_ptr;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic              r_sram_we;
  logic [ADDR_W-1:0] r_sram_raddr;
  logic [ADDR_W-1:0] r_sram_waddr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [N_REQ-1:0]  r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_dat;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid     (req_if.req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .winner_id (w_winner)
  );

  // Grant is combinational off req_valid; suppressed while disabled or in reset.
  assign req_if.req_ready = (arb_en && !reset) ? w_grant : '0;
  assign w_accept         = |(req_if.req_valid & req_if.req_ready);
  assign w_ptr_nxt        = (w_winner == id_t'(N_REQ - 1)) ? '0 : w_winner + 2'd1;

  // Mux the winning requester's command.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == id_t'(i)) begin
        w_sel_we    = req_if.req_we[i];
        w_sel_addr  = req_if.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = req_if.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rsp_onehot[i] = (r_tag2.id == id_t'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_tag1       <= '0;
      r_tag2       <= '0;
      r_sram_we    <= 1'b0;
      r_sram_raddr <= '0;
      r_sram_waddr <= '0;
      r_sram_wdata <= '0;
      r_rsp_vld    <= '0;
      r_rsp_dat    <= '0;
    end else begin
      r_sram_we <= w_accept && w_sel_we;
      if (w_accept) begin
        r_ptr <= w_ptr_nxt;
        // Only the bus used by this access moves; the other holds its last value.
        if (w_sel_we) begin
          r_sram_waddr <= w_sel_addr;
          r_sram_wdata <= w_sel_wdata;
        end else begin
          r_sram_raddr <= w_sel_addr;
        end
      end
      // Stage 1 lines up with the address on the pins, stage 2 with sram_read_data.
      r_tag1.valid <= w_accept && !w_sel_we;
      r_tag1.id    <= w_winner;
      r_tag2       <= r_tag1;
      r_rsp_vld    <= r_tag2.valid ? w_rsp_onehot : '0;
      if (r_tag2.valid) begin
        r_rsp_dat <= sram_read_data;
      end
    end
  end

  assign sram_we          = r_sram_we;
  assign sram_read_addr   = r_sram_raddr;
  assign sram_write_addr  = r_sram_waddr;
  assign sram_write_data  = r_sram_wdata;
  assign req_if.rsp_valid = r_rsp_vld;
  assign req_if.rsp_data  = r_rsp_dat;
  assign arb_busy         = (|req_if.req_valid) | r_tag1.valid | r_tag2.valid;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (N_REQ=2) with an SRAM model and a response scoreboard.
module tb_sram_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct {
    int          id;
    logic [15:0] dat;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          arb_en;
  logic          arb_busy;
  logic [DW-1:0] sram_read_data;
  logic          sram_we;
  logic [AW-1:0] sram_read_addr;
  logic [AW-1:0] sram_write_addr;
  logic [DW-1:0] sram_write_data;

  logic [15:0] mem     [4096];
  logic [15:0] ref_mem [4096];

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rsp = 0;
  int   cyc   = 0;
  int   base;

  sram_port_arbiter_if #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) rif ();

  sram_port_arbiter #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .arb_en          (arb_en),
    .req_if          (rif),
    .arb_busy        (arb_busy),
    .sram_read_data  (sram_read_data),
    .sram_we         (sram_we),
    .sram_read_addr  (sram_read_addr),
    .sram_write_addr (sram_write_addr),
    .sram_write_data (sram_write_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: write commits at the end of the sram_we cycle, read data one cycle after address.
  always @(posedge clk) begin
    if (sram_we) mem[sram_write_addr] <= sram_write_data;
    sram_read_data <= mem[sram_read_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic we, input logic [11:0] a,
                       input logic [15:0] d);
    rif.req_valid[i]          = v;
    rif.req_we[i]             = we;
    rif.req_addr[i*AW +: AW]  = a;
    rif.req_wdata[i*DW +: DW] = d;
  endtask

  // Called at the negedge of the accept cycle.
  task automatic push_rd(input int id, input logic [11:0] a);
    exp_q.push_back('{id: id, dat: ref_mem[a], cyc: cyc});
  endtask

  // Response monitor: every rsp_valid must match the oldest expected read, 3 cycles after accept.
  always @(negedge clk) begin
    if (rif.rsp_valid !== '0) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rif.rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_vld", 32'(rif.rsp_valid), 32'(1 << mon_e.id));
        chk("rsp_dat", 32'(rif.rsp_data), 32'(mon_e.dat));
        chk("rsp_lat", cyc - mon_e.cyc, 32'd3);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a]     <= 16'(a) ^ 16'h5A00;
      ref_mem[a]  = 16'(a) ^ 16'h5A00;
    end
    mem[5]     <= 16'hBEEF;
    ref_mem[5]  = 16'hBEEF;

    // Reset: no grant while reset is high, registers at reset values afterwards.
    reset  = 1'b1;
    arb_en = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h000, 16'h0);
    drive(1, 1'b1, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("ready_in_reset", 32'(rif.req_ready), 32'd0);
    tick();
    drive(0, 1'b0, 1'b0, 12'h000, 16'h0);
    drive(1, 1'b0, 1'b0, 12'h000, 16'h0);
    @(negedge clk);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_raddr", 32'(sram_read_addr), 32'd0);
    chk("rst_waddr", 32'(sram_write_addr), 32'd0);
    chk("rst_wdata", 32'(sram_write_data), 32'd0);
    chk("rst_rsp_vld", 32'(rif.rsp_valid), 32'd0);
    chk("rst_rsp_dat", 32'(rif.rsp_data), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    tick();
    reset = 1'b0;

    // Single read of 0x005 by requester 0.
    drive(0, 1'b1, 1'b0, 12'h005, 16'h0);
    @(negedge clk);
    chk("rd1_ready", 32'(rif.req_ready), 32'h1);
    push_rd(0, 12'h005);
    tick();
    drive(0, 1'b0, 1'b0, 12'h005, 16'h0);
    @(negedge clk);
    chk("rd1_raddr", 32'(sram_read_addr), 32'h005);
    chk("rd1_we", 32'(sram_we), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("rd1_rsp_vld", 32'(rif.rsp_valid), 32'h1);
    chk("rd1_rsp_dat", 32'(rif.rsp_data), 32'hBEEF);
    tick();

    // Fresh reset so contention starts from ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Contention: both requesters read continuously; grants alternate 0,1,0,1...
    drive(0, 1'b1, 1'b0, 12'h010, 16'h0);
    drive(1, 1'b1, 1'b0, 12'h020, 16'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("cont_grant", 32'(rif.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      push_rd(k % 2, (k % 2 == 0) ? 12'h010 : 12'h020);
      tick();
    end
    drive(0, 1'b0, 1'b0, 12'h010, 16'h0);
    drive(1, 1'b0, 1'b0, 12'h020, 16'h0);
    repeat (4) tick();

    // Write then read of 0x0FF by requester 1.
    drive(1, 1'b1, 1'b1, 12'h0FF, 16'h1234);
    @(negedge clk);
    chk("wr_ready", 32'(rif.req_ready), 32'h2);
    ref_mem[12'h0FF] = 16'h1234;
    tick();
    drive(1, 1'b1, 1'b0, 12'h0FF, 16'h0);
    @(negedge clk);
    chk("wr_ready2", 32'(rif.req_ready), 32'h2);
    chk("wr_we", 32'(sram_we), 32'd1);
    chk("wr_waddr", 32'(sram_write_addr), 32'h0FF);
    chk("wr_wdata", 32'(sram_write_data), 32'h1234);
    push_rd(1, 12'h0FF);
    tick();
    drive(1, 1'b0, 1'b0, 12'h0FF, 16'h0);
    @(negedge clk);
    chk("wr_we_one_cycle", 32'(sram_we), 32'd0);
    chk("raw_raddr", 32'(sram_read_addr), 32'h0FF);
    tick();
    tick();
    @(negedge clk);
    chk("raw_rsp_vld", 32'(rif.rsp_valid), 32'h2);
    chk("raw_rsp_dat", 32'(rif.rsp_data), 32'h1234);
    tick();

    // arb_en drop after three back-to-back reads.
    base = n_rsp;
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b0, 12'(12'h100 + k), 16'h0);
      @(negedge clk);
      chk("en_ready", 32'(rif.req_ready), 32'h1);
      push_rd(0, 12'(12'h100 + k));
      tick();
    end
    arb_en = 1'b0;
    drive(0, 1'b1, 1'b0, 12'h103, 16'h0);
    @(negedge clk);
    chk("dis_ready", 32'(rif.req_ready), 32'd0);
    chk("dis_busy_vld", 32'(arb_busy), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 12'h103, 16'h0);
    @(negedge clk);
    chk("dis_ready2", 32'(rif.req_ready), 32'd0);
    chk("dis_busy_pipe", 32'(arb_busy), 32'd1);
    tick();
    @(negedge clk);
    chk("dis_busy_idle", 32'(arb_busy), 32'd0);
    tick();
    @(negedge clk);
    chk("dis_rsp_count", n_rsp - base, 32'd3);
    // Pointer held at 1 while disabled.
    arb_en = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h030, 16'h0);
    drive(1, 1'b1, 1'b0, 12'h040, 16'h0);
    #1;
    chk("reen_grant", 32'(rif.req_ready), 32'h2);
    push_rd(1, 12'h040);
    tick();
    drive(0, 1'b0, 1'b0, 12'h030, 16'h0);
    drive(1, 1'b0, 1'b0, 12'h040, 16'h0);
    repeat (4) tick();

    // Reset one cycle after a read is accepted: the read is dropped.
    drive(0, 1'b1, 1'b0, 12'h0AB, 16'h0);
    @(negedge clk);
    chk("mid_ready", 32'(rif.req_ready), 32'h1);
    tick();
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 12'h010, 16'h0);
    drive(1, 1'b1, 1'b0, 12'h020, 16'h0);
    @(negedge clk);
    chk("mid_ready_rst", 32'(rif.req_ready), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_sram_we", 32'(sram_we), 32'd0);
    chk("mid_raddr", 32'(sram_read_addr), 32'd0);
    chk("mid_waddr", 32'(sram_write_addr), 32'd0);
    chk("mid_wdata", 32'(sram_write_data), 32'd0);
    chk("mid_rsp_vld", 32'(rif.rsp_valid), 32'd0);
    chk("mid_rsp_dat", 32'(rif.rsp_data), 32'd0);
    chk("mid_next_grant", 32'(rif.req_ready), 32'h1);
    push_rd(0, 12'h010);
    tick();
    drive(0, 1'b0, 1'b0, 12'h010, 16'h0);
    drive(1, 1'b0, 1'b0, 12'h020, 16'h0);
    @(negedge clk);
    chk("mid_no_rsp_a", 32'(rif.rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("mid_no_rsp_b", 32'(rif.rsp_valid), 32'd0);
    repeat (5) tick();

    @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    chk("rsp_total", n_rsp, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter that shares the single-port work SRAM (12-bit address, 16-bit data, separate read/write address buses, one `sram_we`) between up to four requesters, e.g. the DUT compute engine, a host loader and a result drain. It sits between the requesters and the SRAM pins, accepts at most one access per cycle, and routes each read response back to the issuing requester. It performs no data transformation and no forwarding.

## Interface
- `N_REQ`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 12: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `arb_en` in 1: when low, no new grants; in-flight reads still complete.
- `req_valid` in N_REQ: per-requester access request.
- `req_we` in N_REQ: 1 = write, 0 = read.
- `req_addr` in N_REQ*ADDR_W: flattened, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata` in N_REQ*DATA_W: flattened write data.
- `req_ready` out N_REQ: one-hot-or-zero grant; accept occurs when `req_valid[i] && req_ready[i]`.
- `rsp_valid` out N_REQ: one-hot-or-zero read-response strobe.
- `rsp_data` out DATA_W: read data, qualified by `rsp_valid`.
- `arb_busy` out 1: any `req_valid` high or any read in flight.
- `sram_read_data` in DATA_W: SRAM read data.
- `sram_we` out 1, `sram_read_addr` out ADDR_W, `sram_write_addr` out ADDR_W, `sram_write_data` out DATA_W: SRAM control signals, all registered.

## Operation
- Round-robin pointer `ptr` (0..N_REQ-1). The winner is the first `i` with `req_valid[i]=1`, scanning from `ptr` upward with wrap.
- `req_ready[winner]=1` combinationally in the same cycle, only if `arb_en=1`. `req_ready` may depend on `req_valid`. Requesters must hold `req_*` stable until accepted.
- On accept: `ptr <= (winner+1) mod N_REQ`. With no accept, `ptr` holds.
- Accepted write: register `sram_we=1`, `sram_write_addr`, `sram_write_data`. No response is generated.
- Accepted read: register `sram_we=0` and `sram_read_addr`. Push `{valid, id}` into a 2-stage tag pipeline.
- Idle cycles: `sram_we=0`. Address and data registers hold their last values.
- Tag pipeline stage 2 valid: `rsp_data <= sram_read_data` and `rsp_valid[id] <= 1`, both registered.
- `arb_en` deasserted mid-stream: the tag pipeline drains normally and `ptr` holds.
- Read-after-write to the same address in consecutive accepts returns the new data, because the SRAM commits a write at the end of the `sram_we` cycle. No forwarding logic is needed.

## Timing
- Reset values: `sram_we=0`; `sram_read_addr`, `sram_write_addr`, `sram_write_data` = 0; `rsp_valid=0`; `rsp_data=0`; `ptr=0`; tag pipeline cleared. `req_ready` is 0 during reset.
- Accept in cycle N:
  - SRAM signals driven in cycle N+1.
  - `sram_read_data` valid in cycle N+2.
  - `rsp_valid`/`rsp_data` valid in cycle N+3, for exactly one cycle.
- Read latency is 3 cycles. Throughput is 1 access per cycle, and back-to-back reads return back-to-back responses in accept order.
- Requesters must always be able to accept a response (no back-pressure on `rsp_*`).
- Reset mid-operation: all in-flight reads are dropped silently, with no `rsp_valid` after reset deasserts. `sram_we` is 0 in the cycle after reset is sampled.
- Simultaneous requests from all N_REQ requesters: each is granted once per N_REQ cycles, in pointer order.
- Single active requester: granted every cycle.
- `arb_busy` is combinational: `|req_valid | |tag_valid`.

## Structure
- Package `sram_arb_pkg`: `ADDR_W`, `DATA_W`, `MAX_REQ=4`, `id_t` (2-bit requester id) and the tag struct `{logic valid; id_t id;}`.
- Sub-module `rr_pick`: inputs `valid[N_REQ]` and `ptr`; outputs `grant` (one-hot) and `winner_id`. Purely combinational.
- Top level holds `ptr`, the SRAM output registers, the 2-deep tag pipeline and the response register.

## Test plan
- **Single read.** After reset, the target has SRAM[0x005]=0xBEEF. Requester 0 reads 0x005, accepted in cycle N. Required: `sram_read_addr=0x005` and `sram_we=0` in N+1; `rsp_valid=2'b01` and `rsp_data=0xBEEF` in N+3.
- **Contention, N_REQ=2.** Both requesters continuously read 0x010 and 0x020. Required:
  - Grants alternate 0,1,0,1, starting with 0.
  - Responses alternate in the same order, 3 cycles after each grant.
  - No cycle without a grant.
- **Write then read.** Requester 1 writes 0x1234 to 0x0FF, then reads 0x0FF on the next cycle. Required: `sram_we` high for exactly one cycle with `sram_write_addr=0x0FF`; `rsp_data=0x1234` on `rsp_valid[1]`.
- **`arb_en` drop.** Issue reads on 3 consecutive cycles, then drop `arb_en`. Required: all 3 responses still arrive; `req_ready=0` while `arb_en=0`; `arb_busy` falls once the pipeline is empty and `req_valid` is low.
- **Reset mid-flight.** Assert `reset` 1 cycle after a read is accepted. Required: no `rsp_valid` ever appears for that read; all outputs return to their reset values; the next grant goes to requester 0.
